// File: rtl/wb_lsu_master.sv
// Wishbone initiator for single byte/half/word/tag loads and stores from the memory stage.
// Bus fields stay frozen for POST_ACK_HOLD cycles after ack so the slave can finish its post-ack phases.
module wb_lsu_master #(
    parameter int WB_DATA_WIDTH     = 32,
    parameter int WB_ADDR_WIDTH     = 32,
    parameter int WB_SEL_WIDTH      = WB_DATA_WIDTH / 8,
    parameter int GRANULE_TAG_WIDTH = 4,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int POST_ACK_HOLD     = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_signed_i,
    input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]               rsp_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > POST_ACK_HOLD) ? TIMEOUT_CYCLES : POST_ACK_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, RESP_ERR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic             signed_q;

    function automatic logic [WB_SEL_WIDTH-1:0] sel_of(input logic [1:0] size);
        case (size)
            2'b00:   sel_of = WB_SEL_WIDTH'(4'b0001);
            2'b01:   sel_of = WB_SEL_WIDTH'(4'b0011);
            2'b10:   sel_of = WB_SEL_WIDTH'(4'b1111);
            default: sel_of = WB_SEL_WIDTH'(4'b0101);
        endcase
    endfunction

    function automatic logic [WB_DATA_WIDTH-1:0] wdata_of(input logic [1:0] size,
                                                          input logic [WB_DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   wdata_of = {24'b0, d[7:0]};
            2'b01:   wdata_of = {16'b0, d[15:0]};
            2'b10:   wdata_of = d;
            default: wdata_of = WB_DATA_WIDTH'(d[GRANULE_TAG_WIDTH-1:0]);
        endcase
    endfunction

    function automatic logic [WB_DATA_WIDTH-1:0] load_of(input logic [1:0] size, input logic sg,
                                                         input logic [WB_DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   load_of = {{24{sg & d[7]}}, d[7:0]};
            2'b01:   load_of = {{16{sg & d[15]}}, d[15:0]};
            2'b10:   load_of = d;
            default: load_of = WB_DATA_WIDTH'(d[GRANULE_TAG_WIDTH-1:0]);
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        misaligned = ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00));
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= ERR_OK;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        size_q      <= req_size_i;
                        signed_q    <= req_signed_i;
                        if (misaligned(req_size_i, req_addr_i[1:0])) begin
                            // Error answer is launched here so it lands one cycle after accept.
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= ERR_ALIGN;
                            rsp_rdata_o <= '0;
                            state       <= RESP_ERR;
                        end else begin
                            wb_addr_o <= req_addr_i;
                            wb_data_o <= wdata_of(req_size_i, req_wdata_i);
                            wb_sel_o  <= sel_of(req_size_i);
                            wb_we_o   <= req_we_i;
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            cnt       <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ERR_OK;
                        rsp_rdata_o <= wb_we_o ? '0 : load_of(size_q, signed_q, wb_data_i);
                        cnt         <= CNT_W'(POST_ACK_HOLD);
                        state       <= HOLD;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ERR_TMO;
                        rsp_rdata_o <= '0;
                        cnt         <= CNT_W'(POST_ACK_HOLD);
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RESP_ERR: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomized bench for wb_lsu_master: a timeline model predicts every cycle of bus and response activity.
module tb_wb_lsu_master;
    localparam int T = 8;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_data_i = '0;

    wb_lsu_master #(.TIMEOUT_CYCLES(T), .POST_ACK_HOLD(P)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_data_i(wb_data_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    // Timeline model, in edge numbers: the value of ecount during the cycle after that edge.
    int          acc_e = 0, end_e = 0, rsp_e = -1, rdy_e = 0;
    logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0;
    logic [1:0]  m_err = 2'b00;

    logic [31:0] last_rdata = '0;
    logic [1:0]  last_err = 2'b00;
    int          cyc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    function automatic logic [3:0] f_sel(input logic [1:0] sz);
        logic [3:0] tbl [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0101};
        return tbl[sz];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
        longint unsigned mod [4] = '{256, 65536, 64'h1_0000_0000, 16};
        longint unsigned v = d;
        v = v % mod[sz];
        return v[31:0];
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic sg, input logic [31:0] d);
        longint v = d;
        if (sz == 2'd0) begin v = v % 256;   if (sg && v >= 128)   v -= 256;   end
        if (sz == 2'd1) begin v = v % 65536; if (sg && v >= 32768) v -= 65536; end
        if (sz == 2'd3) v = v % 16;
        return v[31:0];
    endfunction

    function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    always @(negedge clk) begin
        automatic int e = ecount;
        automatic logic cyc_x = (e >= acc_e) && (e < end_e);
        chk("ready", req_ready_o, e >= rdy_e);
        chk("cyc", wb_cyc_o, cyc_x);
        chk("stb", wb_stb_o, cyc_x);
        chk("rsp_valid", rsp_valid_o, e == rsp_e);
        if (e == rsp_e) begin
            chk("rsp_rdata", rsp_rdata_o, m_rdata);
            chk("rsp_err", rsp_err_o, m_err);
        end
        chk("wb_addr", wb_addr_o, m_addr);
        chk("wb_data", wb_data_o, m_data);
        chk("wb_sel", wb_sel_o, m_sel);
        chk("wb_we", wb_we_o, m_we);
    end

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            last_rdata <= rsp_rdata_o;
            last_err   <= rsp_err_o;
        end
        if (wb_cyc_o) cyc_cnt <= cyc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d >= 0: ack seen d cycles after the earliest slot; -1: never ack (plus a stray late ack);
    // -2: never ack and return right after accept.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] sdata);
        int guard = 0;
        int a_e;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_signed_i = sg;
        req_addr_i = addr; req_wdata_i = wdata;
        do begin tick(); guard++; end while (ecount < rdy_e + 1 && guard < 100);
        if (guard >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_wait: got no accept slot, expected one within 100 cycles");
        end
        acc_e = ecount;
        req_valid_i = 1'b0; req_we_i = $urandom; req_size_i = $urandom; req_signed_i = $urandom;
        req_addr_i = $urandom; req_wdata_i = $urandom;
        if (f_mis(sz, addr)) begin
            end_e = acc_e; rsp_e = acc_e; rdy_e = acc_e + 1;
            m_err = 2'b01; m_rdata = '0;
            return;
        end
        m_addr = addr; m_data = f_wdata(sz, wdata); m_sel = f_sel(sz); m_we = we;
        if (d >= 0) begin
            a_e = acc_e + 2 + d;
            end_e = a_e; rsp_e = a_e; rdy_e = a_e + P;
            m_err = 2'b00; m_rdata = we ? 32'h0 : f_load(sz, sg, sdata);
            while (ecount < a_e - 1) tick();
            wb_ack_i = 1'b1; wb_data_i = sdata;
            tick();
            wb_ack_i = 1'b0; wb_data_i = $urandom;
        end else begin
            end_e = acc_e + T; rsp_e = acc_e + T; rdy_e = acc_e + T + P;
            m_err = 2'b10; m_rdata = '0;
            if (d == -1) begin
                while (ecount < acc_e + T) tick();
                wb_ack_i = 1'b1; wb_data_i = $urandom;
                tick();
                wb_ack_i = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (ecount < rdy_e && guard < 100) begin tick(); guard++; end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int c0;
        #1 wb_rst_i = 1'b1;
        #1;
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_err", rsp_err_o, 2'b00);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_addr", wb_addr_o, 32'h0);
        repeat (3) @(negedge clk);
        #2 wb_rst_i = 1'b0;

        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 32'h0000_0080);
        chk("bs_sel", wb_sel_o, 4'b0001);
        wait_idle();
        chk("bs_rdata", last_rdata, 32'hFFFF_FF80);
        chk("bs_err", last_err, 2'b00);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 32'h0000_0080);
        wait_idle();
        chk("bu_rdata", last_rdata, 32'h0000_0080);

        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD, 0, 32'h0);
        chk("hs_data", wb_data_o, 32'h0000_ABCD);
        chk("hs_sel", wb_sel_o, 4'b0011);
        chk("hs_we", wb_we_o, 1'b1);
        chk("hs_cyc", wb_cyc_o, 1'b0);
        wait_idle();

        c0 = cyc_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 32'h0);
        wait_idle();
        chk("mw_err", last_err, 2'b01);
        chk("mw_rdata", last_rdata, 32'h0);
        chk("mw_nocyc", cyc_cnt - c0, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0, 32'h0);
        wait_idle();
        chk("mh_err", last_err, 2'b01);

        issue(1'b1, 2'd3, 1'b0, 32'h40, 32'h0000_000A, 1, 32'h0);
        chk("tw_sel", wb_sel_o, 4'b0101);
        chk("tw_data", wb_data_o, 32'h0000_000A);
        wait_idle();
        issue(1'b0, 2'd3, 1'b1, 32'h40, 32'h0, 0, 32'hFFFF_FFF5);
        wait_idle();
        chk("tr_rdata", last_rdata, 32'h0000_0005);

        c0 = cyc_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, -1, 32'h0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("to_cycles", cyc_cnt - c0, T);
        chk("to_err", last_err, 2'b10);

        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -2, 32'h0);
        tick(); tick();
        #2 wb_rst_i = 1'b1;
        end_e = 0; rsp_e = -1; rdy_e = 0;
        m_addr = '0; m_data = '0; m_sel = '0; m_we = 1'b0;
        #1;
        chk("rr_cyc", wb_cyc_o, 1'b0);
        chk("rr_stb", wb_stb_o, 1'b0);
        chk("rr_ready", req_ready_o, 1'b1);
        chk("rr_rsp", rsp_valid_o, 1'b0);
        @(negedge clk);
        #2 wb_rst_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            issue($urandom, $urandom, $urandom, $urandom, $urandom, d, $urandom);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 2000000");
        $fatal(1);
    end
endmodule
